// File: rtl/fpga_fabric_cfg.sv
// Configurable CLB fabric: NUM_CLB slices of SLICE_W bits with per-slice op and
// carry-in routing, loaded from a byte-stream bitfile and committed atomically.
module fpga_fabric_cfg #(
  parameter int NUM_CLB = 4,
  parameter int SLICE_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic [7:0]                 cfg_byte,
  output logic                       cfg_ready,
  output logic                       cfg_done,
  output logic                       cfg_err,
  input  logic                       c_ext,
  input  logic                       in_valid,
  input  logic [NUM_CLB*SLICE_W-1:0] In_1,
  input  logic [NUM_CLB*SLICE_W-1:0] In_2,
  output logic                       in_ready,
  output logic [NUM_CLB*SLICE_W-1:0] Sum,
  output logic                       Cout,
  output logic                       out_valid
);

  localparam int DW = NUM_CLB * SLICE_W;
  localparam int NB = NUM_CLB / 2;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

  localparam logic [1:0] ST_UNCONFIG = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_CLB*4-1:0] shadow_q, shadow_d;
  logic [NUM_CLB*4-1:0] active_q, active_d;
  logic [DW-1:0]        sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 accept;
  logic [DW-1:0]        res;
  logic                 res_cout;
  logic                 carry;
  logic                 cin;
  logic [3:0]           nib;
  logic [SLICE_W-1:0]   op_a, op_b;
  logic [SLICE_W:0]     add_w;

  assign cfg_ready = (state_q == ST_LOAD);
  assign cfg_done  = (state_q == ST_RUN);
  assign in_ready  = (state_q == ST_RUN);
  assign accept    = in_valid && (state_q == ST_RUN);

  // Restart has priority over a byte arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    cfg_err_d = cfg_valid && (state_q != ST_LOAD);
    if (cfg_start) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      shadow_d = '0;
    end else if (cfg_valid && (state_q == ST_LOAD)) begin
      for (int b = 0; b < NB; b++) begin
        if (cnt_q == CW'(b)) shadow_d[b*8 +: 8] = cfg_byte;
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_BYTE) begin
        active_d = shadow_d;
        state_d  = ST_RUN;
        cnt_d    = '0;
      end
    end
  end

  // Carry ripples LSB slice to MSB slice; logic ops break the chain with 0.
  always_comb begin
    carry = c_ext;
    res   = '0;
    nib   = '0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    add_w = '0;
    for (int i = 0; i < NUM_CLB; i++) begin
      nib  = active_q[i*4 +: 4];
      op_a = In_1[i*SLICE_W +: SLICE_W];
      op_b = In_2[i*SLICE_W +: SLICE_W];
      case (nib[3:2])
        2'b00:   cin = carry;
        2'b01:   cin = 1'b0;
        2'b10:   cin = 1'b1;
        default: cin = c_ext;
      endcase
      add_w = {1'b0, op_a} + {1'b0, op_b} + {{SLICE_W{1'b0}}, cin};
      case (nib[1:0])
        2'b00: begin
          res[i*SLICE_W +: SLICE_W] = add_w[SLICE_W-1:0];
          carry = add_w[SLICE_W];
        end
        2'b01: begin
          res[i*SLICE_W +: SLICE_W] = op_a & op_b;
          carry = 1'b0;
        end
        2'b10: begin
          res[i*SLICE_W +: SLICE_W] = op_a | op_b;
          carry = 1'b0;
        end
        default: begin
          res[i*SLICE_W +: SLICE_W] = op_a ^ op_b;
          carry = 1'b0;
        end
      endcase
    end
    res_cout = carry;
  end

  always_comb begin
    sum_d       = accept ? res : sum_q;
    cout_d      = accept ? res_cout : cout_q;
    out_valid_d = accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_UNCONFIG;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fpga_fabric_cfg.sv
// Scenario bench for fpga_fabric_cfg with a slice-level arithmetic reference model.
module tb_fpga_fabric_cfg;

  localparam int NUM_CLB = 4;
  localparam int SW      = 2;
  localparam int DW      = NUM_CLB * SW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_byte = '0;
  logic          cfg_ready, cfg_done, cfg_err;
  logic          c_ext = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] In_1 = '0;
  logic [DW-1:0] In_2 = '0;
  logic          in_ready;
  logic [DW-1:0] Sum;
  logic          Cout;
  logic          out_valid;

  int vectors = 0;
  int miscompares = 0;
  logic [NUM_CLB*4-1:0] model_cfg = '0;

  fpga_fabric_cfg #(.NUM_CLB(NUM_CLB), .SLICE_W(SW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_byte(cfg_byte), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .c_ext(c_ext), .in_valid(in_valid), .In_1(In_1), .In_2(In_2), .in_ready(in_ready),
    .Sum(Sum), .Cout(Cout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Returns {cout, sum} computed slice by slice with integer arithmetic.
  function automatic logic [DW:0] ref_calc(input logic [NUM_CLB*4-1:0] cfg,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic cx);
    int carry, av, bv, s, cin, op, sel, mask;
    logic [DW-1:0] sum;
    mask  = (1 << SW) - 1;
    carry = int'(cx);
    sum   = '0;
    for (int i = 0; i < NUM_CLB; i++) begin
      op  = int'(cfg >> (4 * i)) & 3;
      sel = int'(cfg >> (4 * i + 2)) & 3;
      av  = int'(a >> (SW * i)) & mask;
      bv  = int'(b >> (SW * i)) & mask;
      cin = (sel == 0) ? carry : (sel == 1) ? 0 : (sel == 2) ? 1 : int'(cx);
      case (op)
        0: begin s = av + bv + cin; carry = s >> SW; s = s & mask; end
        1: begin s = av & bv; carry = 0; end
        2: begin s = av | bv; carry = 0; end
        default: begin s = av ^ bv; carry = 0; end
      endcase
      sum = sum | DW'(s << (SW * i));
    end
    return {carry[0], sum};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cx,
                          output logic [DW-1:0] s, output logic co, output logic ov);
    In_1 = a; In_2 = b; c_ext = cx; in_valid = 1'b1;
    tick();
    s = Sum; co = Cout; ov = out_valid;
    in_valid = 1'b0;
    $display("op a=%h b=%h c_ext=%b -> out_valid=%b Sum=%h Cout=%b", a, b, cx, ov, s, co);
  endtask

  task automatic load2(input logic [7:0] b0, input logic [7:0] b1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_byte = b0;
    tick();
    cfg_byte = b1;
    tick();
    cfg_valid = 1'b0;
    model_cfg = {b1, b0};
    $display("load %h %h -> cfg_done=%b", b0, b1, cfg_done);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(); tick();
    vectors++;
    if (cfg_done !== 1'b0 || cfg_ready !== 1'b0 || in_ready !== 1'b0 || Sum !== '0 ||
        Cout !== 1'b0 || out_valid !== 1'b0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: done=%b ready=%b in_ready=%b Sum=%h Cout=%b ov=%b err=%b expected all 0",
               cfg_done, cfg_ready, in_ready, Sum, Cout, out_valid, cfg_err);
    end
    reset = 1'b1;
    tick();
    In_1 = 8'h12; In_2 = 8'h34; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL unconfig_op: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (Sum !== 8'h00 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL unconfig_sum: Sum=%h Cout=%b expected 00 0", Sum, Cout);
    end
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL unconfig_err: cfg_err=%b expected 1", cfg_err);
    end
  endtask

  task automatic test_add_chain;
    logic [DW-1:0] s; logic co, ov;
    load2(8'h00, 8'h00);
    vectors++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_done: done=%b ready=%b in_ready=%b expected 1 0 1", cfg_done, cfg_ready, in_ready);
    end
    apply_op(8'hFF, 8'h01, 1'b0, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'h00 || co !== 1'b1) begin
      miscompares++;
      $display("FAIL add_chain_c0: ov=%b Sum=%h Cout=%b expected 1 00 1", ov, s, co);
    end
    apply_op(8'hFF, 8'h01, 1'b1, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'h01 || co !== 1'b1) begin
      miscompares++;
      $display("FAIL add_chain_c1: ov=%b Sum=%h Cout=%b expected 1 01 1", ov, s, co);
    end
    In_1 = 8'h00;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || Sum !== 8'h01 || Cout !== 1'b1) begin
      miscompares++;
      $display("FAIL hold: ov=%b Sum=%h Cout=%b expected 0 01 1", out_valid, Sum, Cout);
    end
  endtask

  task automatic test_mixed_ops;
    logic [DW-1:0] s; logic co, ov;
    load2(8'h74, 8'h21);
    apply_op(8'hA5, 8'h3C, 1'b1, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'hA9 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL mixed_ops: ov=%b Sum=%h Cout=%b expected 1 a9 0", ov, s, co);
    end
  endtask

  task automatic test_isolated_cin;
    logic [DW-1:0] s; logic co, ov;
    load2(8'h88, 8'h88);
    for (int cx = 0; cx < 2; cx++) begin
      apply_op(8'hC0, 8'h00, cx[0], s, co, ov);
      vectors++;
      if (ov !== 1'b1 || s !== 8'h15 || co !== 1'b1) begin
        miscompares++;
        $display("FAIL isolated_cin c_ext=%0d: ov=%b Sum=%h Cout=%b expected 1 15 1", cx, ov, s, co);
      end
    end
  endtask

  task automatic test_abort;
    logic [DW-1:0] s; logic co, ov;
    load2(8'h00, 8'h00);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_load: ready=%b done=%b expected 1 0", cfg_ready, cfg_done);
    end
    cfg_valid = 1'b1; cfg_byte = 8'h77;
    tick();
    cfg_valid = 1'b0;
    reset = 1'b0;
    #2;
    vectors++;
    if (cfg_ready !== 1'b0 || cfg_done !== 1'b0 || in_ready !== 1'b0 || Sum !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ready=%b done=%b in_ready=%b Sum=%h expected 0 0 0 00",
               cfg_ready, cfg_done, in_ready, Sum);
    end
    tick();
    reset = 1'b1;
    model_cfg = '0;
    tick();
    apply_op(8'hFF, 8'h01, 1'b0, s, co, ov);
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_op: ov=%b expected 0", ov);
    end
    load2(8'h00, 8'h00);
    apply_op(8'hFF, 8'h01, 1'b0, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'h00 || co !== 1'b1) begin
      miscompares++;
      $display("FAIL reload: ov=%b Sum=%h Cout=%b expected 1 00 1", ov, s, co);
    end
  endtask

  task automatic test_restart_drop;
    logic [DW-1:0] s; logic co, ov;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_byte = 8'h74;
    tick();
    cfg_start = 1'b1; cfg_byte = 8'h88;
    tick();
    cfg_start = 1'b0; cfg_byte = 8'h74;
    tick();
    vectors++;
    if (cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_drop_mid: ready=%b done=%b expected 1 0", cfg_ready, cfg_done);
    end
    cfg_byte = 8'h21;
    tick();
    cfg_valid = 1'b0;
    model_cfg = 16'h2174;
    vectors++;
    if (cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_drop_done: done=%b expected 1", cfg_done);
    end
    apply_op(8'hA5, 8'h3C, 1'b0, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'hA9 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_drop_result: ov=%b Sum=%h Cout=%b expected 1 a9 0", ov, s, co);
    end
  endtask

  task automatic test_cfg_err;
    logic [DW-1:0] s; logic co, ov;
    cfg_valid = 1'b1; cfg_byte = 8'hFF;
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_pulse: cfg_err=%b expected 1", cfg_err);
    end
    tick();
    vectors++;
    if (cfg_err !== 1'b0 || cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_clear: cfg_err=%b done=%b expected 0 1", cfg_err, cfg_done);
    end
    apply_op(8'hA5, 8'h3C, 1'b0, s, co, ov);
    vectors++;
    if (ov !== 1'b1 || s !== 8'hA9 || co !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_unchanged: ov=%b Sum=%h Cout=%b expected 1 a9 0", ov, s, co);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW:0] exp;
    load2(8'($urandom), 8'($urandom));
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      In_1 = DW'($urandom); In_2 = DW'($urandom); c_ext = 1'($urandom);
      exp = ref_calc(model_cfg, In_1, In_2, c_ext);
      tick();
      $display("b2b a=%h b=%h c_ext=%b -> Sum=%h Cout=%b", In_1, In_2, c_ext, Sum, Cout);
      vectors++;
      if (out_valid !== 1'b1 || {Cout, Sum} !== exp) begin
        miscompares++;
        $display("FAIL back_to_back %0d: ov=%b Cout,Sum=%h expected 1 %h", i, out_valid, {Cout, Sum}, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || {Cout, Sum} !== exp) begin
      miscompares++;
      $display("FAIL b2b_hold: ov=%b Cout,Sum=%h expected 0 %h", out_valid, {Cout, Sum}, exp);
    end
    In_1 = DW'($urandom); In_2 = DW'($urandom); c_ext = 1'($urandom);
    exp = ref_calc(model_cfg, In_1, In_2, c_ext);
    in_valid = 1'b1; cfg_start = 1'b1;
    tick();
    in_valid = 1'b0; cfg_start = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || {Cout, Sum} !== exp || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL last_run_op: ov=%b Cout,Sum=%h ready=%b expected 1 %h 1",
               out_valid, {Cout, Sum}, cfg_ready, exp);
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] s, a, b; logic co, ov, cx;
    logic [DW:0] exp;
    for (int n = 0; n < 16; n++) begin
      load2(8'($urandom), 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        a = DW'($urandom); b = DW'($urandom); cx = 1'($urandom);
        exp = ref_calc(model_cfg, a, b, cx);
        apply_op(a, b, cx, s, co, ov);
        vectors++;
        if (ov !== 1'b1 || {co, s} !== exp) begin
          miscompares++;
          $display("FAIL random cfg=%h a=%h b=%h c=%b: ov=%b Cout,Sum=%h expected 1 %h",
                   model_cfg, a, b, cx, ov, {co, s}, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_chain();
    test_mixed_ops();
    test_isolated_cin();
    test_abort();
    test_restart_drop();
    test_cfg_err();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpga_fabric_cfg.md
Name: fpga_fabric_cfg

Overview:
Parametrised successor to the fixed 4-CLB adder fabric: NUM_CLB slices of SLICE_W bits each, with per-slice operation and carry-in routing. Configuration is loaded as a byte-stream bitfile through a load FSM with a ready/valid handshake and committed atomically. The datapath accepts operands only once configured and produces registered Sum/Cout with 1-cycle latency. It sits where the fixed adder top sits: between the operand sources and the result consumer, fed by the bitfile loader.

Parameters:
NUM_CLB, 4, number of CLB slices; must be even and at least 2.
SLICE_W, 2, bits per slice; data width DW = NUM_CLB*SLICE_W.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_start  in  1  1-cycle pulse; begin or restart a bitfile load
cfg_valid  in  1  cfg_byte valid
cfg_byte  in  8  bitfile byte; low nibble -> CLB 2k, high nibble -> CLB 2k+1 (k = byte index)
cfg_ready  out  1  high in LOAD
cfg_done  out  1  high in RUN
cfg_err  out  1  1-cycle pulse: cfg_valid seen outside LOAD
c_ext  in  1  external carry-in
in_valid  in  1  operands valid
In_1  in  DW  operand A
In_2  in  DW  operand B
in_ready  out  1  high in RUN
Sum  out  DW  registered result
Cout  out  1  registered carry-out of CLB NUM_CLB-1
out_valid  out  1  1-cycle pulse with each result

Behaviour:
- Reset (reset=0, async): state=UNCONFIG; active and shadow config all zero; byte counter=0; Sum=0, Cout=0, out_valid=0, cfg_done=0, cfg_err=0.
- Config nibble per CLB: [1:0] op: 00 ADD, 01 AND, 10 OR, 11 XOR. [3:2] carry-in select: 00 carry-out of CLB i-1 (c_ext for CLB0), 01 constant 0, 10 constant 1, 11 c_ext.
- Slice carry-out: ADD gives the natural carry from a SLICE_W+1-bit sum; logic ops give carry-out 0. The chain is combinational LSB slice to MSB slice within one cycle.
- FSM has three states: UNCONFIG, LOAD, RUN.
  - cfg_start in any state -> LOAD next cycle; counter=0; shadow cleared.
  - In LOAD, each cfg_valid&cfg_ready writes cfg_byte into shadow[counter] and increments counter.
  - On acceptance of byte NUM_CLB/2-1: shadow (including that byte) copies to active; next state RUN.
  - RUN persists until cfg_start or reset.
- Simultaneous cfg_start and cfg_valid in LOAD: restart wins; the byte is discarded and counter=0.
- Active config is untouched during LOAD. A load aborted by cfg_start or reset never partially commits.
- cfg_valid in UNCONFIG or RUN: ignored; cfg_err=1 the following cycle for 1 cycle.
- Datapath: on in_valid&in_ready, the next edge registers Sum and Cout using the active config and c_ext sampled that cycle; out_valid=1 for that cycle only.
  - Sum/Cout hold their value between results.
  - Back-to-back acceptance gives out_valid on consecutive cycles.
- in_valid outside RUN: ignored; no out_valid. A transaction accepted in the last RUN cycle before cfg_start still completes with out_valid.
- Width: Sum is the DW-bit concatenation, CLB0 in bits [SLICE_W-1:0]; no truncation beyond each slice.

Test Plan:
1. Reset, then in_valid=1, In_1=0x12, In_2=0x34 without a load -> in_ready=0, out_valid never asserts, Sum=0x00, Cout=0.
2. Load bytes 0x00,0x00 (all ADD, chained); In_1=0xFF, In_2=0x01, c_ext=0 -> next cycle out_valid=1, Sum=0x00, Cout=1; with c_ext=1 -> Sum=0x01, Cout=1.
3. Load 0x74,0x21 (CLB0 ADD cin=0, CLB1 XOR, CLB2 AND, CLB3 OR); In_1=0xA5, In_2=0x3C -> Sum=0xA9, Cout=0.
4. Load 0x88,0x88 (all ADD, cin=1 isolated); In_1=0xC0, In_2=0x00 -> Sum=0x15, Cout=1.
5. From RUN (config 0x00,0x00): cfg_start, send byte 0x77, assert reset low mid-load, then reload 0x00,0x00 -> after reset, UNCONFIG with cfg_done=0 and active config zero; 0xFF+0x01 -> Sum=0x00, Cout=1. Separately, cfg_start with cfg_valid on byte 1 -> byte dropped; the load needs two more bytes.
6. cfg_valid=1 in RUN -> cfg_err pulses exactly one cycle; config unchanged (re-run scenario 3 result 0xA9).
